// File: rtl/coef_bus_arbiter_if.sv
// Coefficient bus interface: four requester data lanes with their valid bits,
// the one-hot accept strobe and mux select back to the requesters, and the
// registered valid/ready output stage towards the shared consumer.
// master = requesters + consumer side, slave = the arbiter.
interface coef_bus_arbiter_if #(
    parameter int DW = 16
);
    logic [3:0]    req;
    logic [DW-1:0] din0;
    logic [DW-1:0] din1;
    logic [DW-1:0] din2;
    logic [DW-1:0] din3;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          busy;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;

    modport master (
        output req, din0, din1, din2, din3, dout_ready,
        input  gnt, sel, busy, dout, dout_valid
    );

    modport slave (
        input  req, din0, din1, din2, din3, dout_ready,
        output gnt, sel, busy, dout, dout_valid
    );
endinterface

// File: rtl/coef_bus_arbiter.sv
// coef_bus_arbiter: round-robin burst arbiter sharing one coefficient bus
// between four requesters. An owner keeps the bus for up to BURST beats (or
// until it drops req), then the arbiter spends one IDLE cycle re-arbitrating.
// Granted words are registered into a single-entry valid/ready output stage.
// Optional macro COEF_ARB_FIXED_PRIO_EN: when defined, IDLE picks the
// lowest-index requester (0 highest) and no last-owner register exists.
module coef_bus_arbiter #(
    parameter int DW    = 16,
    parameter int BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    coef_bus_arbiter_if.slave bus
);

    // Beat counter is at least one bit wide even when BURST == 1.
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    logic [1:0]    owner;
    logic [CW-1:0] beat_cnt;
    logic [DW-1:0] dout_q;
    logic          dout_valid_q;

`ifndef COEF_ARB_FIXED_PRIO_EN
    logic [1:0]    last;
    logic [1:0]    cand;
    logic          found;
`endif

    logic          out_free;
    logic          beat;
    logic [3:0]    owner_oh;
    logic [DW-1:0] din_sel;
    logic [1:0]    pick;

    // Output stage can take a new word when empty or being drained this cycle.
    always_comb begin
        out_free = !dout_valid_q || bus.dout_ready;
        owner_oh = 4'b0001 << owner;
        beat     = (state == GRANT) && bus.req[owner] && out_free;
        case (owner)
            2'd0:    din_sel = bus.din0;
            2'd1:    din_sel = bus.din1;
            2'd2:    din_sel = bus.din2;
            default: din_sel = bus.din3;
        endcase
    end

`ifdef COEF_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest set req bit wins.
    always_comb begin
        pick = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[k]) begin
                pick = k[1:0];
            end
        end
    end
`else
    // Round robin: first set req bit after the previous owner, wrapping mod 4.
    always_comb begin
        pick  = 2'd0;
        cand  = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + k[1:0];
            if (!found && bus.req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end
`endif

    // Arbitration FSM: owner selection, burst counting and release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= 2'd0;
            beat_cnt <= '0;
`ifndef COEF_ARB_FIXED_PRIO_EN
            last     <= 2'd3;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        owner    <= pick;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!bus.req[owner]) begin
                        // Owner went quiet: give the bus up early.
`ifndef COEF_ARB_FIXED_PRIO_EN
                        last  <= owner;
`endif
                        state <= IDLE;
                    end else if (out_free) begin
                        beat_cnt <= beat_cnt + CW'(1);
                        if (beat_cnt == LAST_BEAT) begin
`ifndef COEF_ARB_FIXED_PRIO_EN
                            last  <= owner;
`endif
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Single-entry output register; a beat and a drain may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else if (beat) begin
            dout_q       <= din_sel;
            dout_valid_q <= 1'b1;
        end else if (bus.dout_ready) begin
            dout_valid_q <= 1'b0;
        end
    end

    // Accept strobe is withheld while the output stage is full and stalled.
    assign bus.gnt        = (state == GRANT) ? (owner_oh & {4{out_free}}) : 4'b0000;
    assign bus.sel        = owner;
    assign bus.busy       = (state == GRANT);
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;

endmodule

// File: doc/coef_bus_arbiter.md
Name: coef_bus_arbiter

Overview:
- Round-robin burst arbiter sharing one 16-bit coefficient bus between four requesters (e.g. memory bank readers, butterfly outputs) in the NTT datapath.
- Generates the 2-bit select for the downstream 4:1 coefficient mux.
- Holds a grant for up to BURST beats, then re-arbitrates.
- Registers the selected word into a single-entry valid/ready output stage that feeds the shared consumer.

Parameters:
- DW, 16, coefficient width.
- BURST, 4, max beats per grant (>=1); counter width is clog2(BURST), minimum 1 bit.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-requester valid; req[i] high = din_i holds a word.
- din0  input  DW  requester 0 data.
- din1  input  DW  requester 1 data.
- din2  input  DW  requester 2 data.
- din3  input  DW  requester 3 data.
- gnt  output  4  one-hot accept strobe; a beat from i transfers when req[i] && gnt[i].
- sel  output  2  current owner index, drives the external 4:1 mux.
- busy  output  1  high in GRANT state.
- dout  output  DW  registered selected word.
- dout_valid  output  1  dout holds a beat.
- dout_ready  input  1  consumer accepts dout this cycle.

Behaviour:
- Reset (async assert, sync release): state=IDLE, owner=0, last=3, beat_cnt=0, dout=0, dout_valid=0. Outputs sel=0, gnt=0, busy=0.
- out_free = !dout_valid || dout_ready.
- IDLE:
  - If req != 0: pick the first set bit scanning last+1, last+2, ... modulo 4. Register it as owner, clear beat_cnt, go to GRANT.
  - If req == 0: stay in IDLE.
  - No beat transfers in IDLE; gnt=0.
- GRANT:
  - gnt = onehot(owner) & {4{out_free}}, combinational.
  - sel = owner.
  - beat = req[owner] && out_free.
- On a beat:
  - dout <= din[owner], dout_valid <= 1, beat_cnt++.
  - If beat_cnt == BURST-1: last <= owner, go to IDLE.
- If req[owner] == 0:
  - No beat; last <= owner, go to IDLE (early release).
- Output stage:
  - If no beat and dout_ready, dout_valid <= 0.
  - A beat and dout_ready in the same cycle keeps dout_valid=1 with the new word. Back-to-back throughput is 1 beat/cycle.
- Latency:
  - req rising in IDLE at cycle 0 -> gnt at cycle 1 -> dout_valid at cycle 2.
  - Re-arbitration costs exactly 1 idle cycle per grant.
- Backpressure: dout_ready=0 with dout_valid=1 forces gnt=0. The owner is retained and beat_cnt is unchanged; no data is lost or duplicated.
- Other requesters' req changes during GRANT are ignored until IDLE.
- Reset mid-burst: immediate return to reset values. Pending dout is discarded, and requester 0 wins next.
- sel is stable for the whole grant, including backpressure cycles.

Optional Feature:
- Macro: COEF_ARB_FIXED_PRIO_EN.
- Defined: IDLE picks the lowest-index set req bit (0 highest). The last register is not implemented; everything else is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Single requester: req=4'b0010, din1=0x0A01..0x0A06, dout_ready=1, BURST=4 -> gnt[1] cycles 1-4, dout 0x0A01..0x0A04 cycles 2-5. IDLE at cycle 5, regrant cycle 6, 0x0A05 at dout cycle 7.
- All request continuously, BURST=4, dout_ready=1 -> grant order 0,1,2,3,0. Each grant has 4 beats, then 1 idle cycle.
- Backpressure: owner 2 streaming, dout_ready=0 for cycles 3-5 -> gnt=0 and dout held at the same word for cycles 3-5. No beat lost; beat_cnt frozen; sel=2 throughout.
- Early release: owner 3 drops req after 2 beats -> IDLE next cycle, last=3. With req=4'b1001 pending, requester 0 is granted next.
- Reset mid-burst: rst_n low for 1 cycle during owner 1's beat 2 -> dout_valid=0, busy=0, sel=0 immediately. After release with req=4'b1111, requester 0 is granted.
- COEF_ARB_FIXED_PRIO_EN defined, req=4'b1111 steady -> requester 0 is granted every time.
